alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue stage that feeds the EX-stage ALU of the pipelined RV32I core. It accepts a fetched instruction plus register-file read data, translates opcode/funct3/funct7 into the 4-bit ALU control encoding, selects operands, and hands one registered bundle per cycle to the ALU. A valid/ready handshake with a 2-entry skid buffer keeps `in_ready` registered. Pipeline flush is supported.

## Interface
- `WIDTH`, 32: datapath width of operands and PC.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: discard all held entries. Takes priority over every other event.
- `in_valid` input 1: upstream holds an instruction.
- `in_ready` output 1: stage can accept. Registered.
- `instr` input 32: RV32I instruction word.
- `pc` input WIDTH: instruction address.
- `rs1_data`, `rs2_data` input WIDTH: register operands.
- `out_valid` output 1: bundle valid toward EX.
- `out_ready` input 1: EX accepts the bundle.
- `alu_a`, `alu_b` output WIDTH: ALU operands.
- `alu_ctrl` output 4: ALU operation code.
- `funct3_0` output 1: `instr[12]` of the issued instruction. Selects inverted branch sense.
- `is_branch` output 1: issued instruction is a conditional branch.
- `illegal` output 1: issued instruction is unsupported.

## Operation
- ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100, SLTU 0101, XOR 0110, SLL 0111, SRL 1000, SRA 1001.
- OP (0110011):
  - funct3 000: SUB if `instr[30]`, else ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR. 101: SRA if `instr[30]`, else SRL. 110: OR. 111: AND.
  - Operands: a = rs1, b = rs2.
- OP-IMM (0010011):
  - Same funct3 map as OP, except funct3 000 is always ADD.
  - b = sign-extended I-immediate. For shifts, b = zero-extended `instr[24:20]`.
- BRANCH (1100011):
  - BEQ/BNE map to SUB. BLT/BGE map to SLT. BLTU/BGEU map to SLTU.
  - a = rs1, b = rs2, `is_branch` = 1.
- LUI: ADD, a = 0, b = U-immediate. AUIPC: ADD, a = pc, b = U-immediate.
- LOAD: ADD, a = rs1, b = I-immediate. STORE: ADD, a = rs1, b = S-immediate.
- JAL and JALR: ADD, a = pc, b = 4.
- Any other opcode, or BRANCH funct3 010/011: handled per Configuration.
- Decode is combinational on the input side. All outputs come from the main register.

## Timing
- Handshake:
  - Transfer in when `in_valid & in_ready`. Transfer out when `out_valid & out_ready`.
  - `in_valid` must hold, with stable data, until accepted.
- Occupancy FSM:
  - EMPTY: accept goes to ONE.
  - ONE: accept without drain goes to FULL (new bundle into skid). Drain without accept goes to EMPTY. Accept plus drain stays ONE (new bundle into main).
  - FULL: drain moves skid into main and goes to ONE. `in_ready` = 0 in FULL, so no accept is possible.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL. Registered from the next state.
- Latency: one cycle from accept to `out_valid` when EMPTY. Throughput is one per cycle while `out_ready` is held high.
- `flush`: next state is EMPTY, `out_valid` = 0, `in_ready` = 1, and a same-cycle input is dropped.
- Reset values: `out_valid` 0, `in_ready` 1, `alu_a`/`alu_b` 0, `alu_ctrl` 0000, `funct3_0` 0, `is_branch` 0, `illegal` 0. State is EMPTY.
- Reset mid-transfer drops all held entries. No partial outputs.
- Payload of the main register is stable while `out_valid & !out_ready`.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined:
  - Unsupported encodings issue with `illegal` = 1, `alu_ctrl` = 1111 (ALU output 0) and operands 0.
  - `is_branch` = 0 for such instructions.
- Not defined:
  - `illegal` is tied 0.
  - Unsupported encodings issue as ADD of rs1 and I-immediate.

## Structure
- Shared package `alu_pkg`:
  - ALU control localparams (ALU_ADD … ALU_SRA, ALU_NONE = 4'b1111).
  - RV32I opcode localparams.
  - Issue-bundle field widths.
- One sub-module, `alu_decode`: purely combinational decoder from instr/pc/rs data to bundle.
- Skid FSM and registers live in `alu_issue_stage`.

## Test plan
- ADD x, SUB x (`instr[30]`=1), SRAI with shamt 4, rs1 = 32'h8000_0000, `out_ready` = 1 -> `alu_ctrl` 0000, 0001, 1001 on consecutive cycles; SRAI gives b = 4.
- BGE with rs1 = 5, rs2 = 7 -> `alu_ctrl` 0100, `funct3_0` 1, `is_branch` 1, a = 5, b = 7.
- LUI `instr` = 32'h12345_0B7 -> a = 0, b = 32'h1234_5000, ctrl 0000.
- `out_ready` = 0 for 3 cycles while `in_valid` = 1:
  - Two bundles accepted, then `in_ready` = 0.
  - Main payload stays stable.
  - After release, bundles drain in order with no loss or duplication.
- `flush` in FULL with `in_valid` = 1 -> next cycle `out_valid` 0, `in_ready` 1; the input is not issued.
- Opcode 7'b1111111 -> with `ALU_ISSUE_ILLEGAL_EN`, `illegal` 1 and ctrl 1111; without it, `illegal` 0 and ctrl 0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, RV32I opcodes,
// issue-bundle field widths and the funct3 -> ALU operation map.
package alu_pkg;

    localparam int INSTR_W = 32;
    localparam int CTRL_W  = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_NONE = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} occ_state_t;

    // sub_en: funct3 000 honours instr[30] (register form only).
    function automatic logic [CTRL_W-1:0] funct3_to_alu(input logic [2:0] f3,
                                                        input logic sub_en,
                                                        input logic alt);
        case (f3)
            3'b000:  return (sub_en && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder: instruction + operands -> ALU issue bundle.
// ALU_ISSUE_ILLEGAL_EN: unsupported encodings issue as ALU_NONE with illegal=1.
module alu_decode
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   rs1_data,
    input  logic [WIDTH-1:0]   rs2_data,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               funct3_0,
    output logic               is_branch,
    output logic               illegal
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] imm_i, imm_s, imm_u, shamt;
    logic             supported;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct3_0 = instr[12];
    assign imm_i    = WIDTH'($signed(instr[31:20]));
    assign imm_s    = WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_u    = WIDTH'($signed({instr[31:12], 12'h000}));
    assign shamt    = WIDTH'(instr[24:20]);

    always_comb begin
        alu_a     = rs1_data;
        alu_b     = imm_i;
        alu_ctrl  = ALU_ADD;
        is_branch = 1'b0;
        supported = 1'b1;
        case (opcode)
            OPC_OP: begin
                alu_b    = rs2_data;
                alu_ctrl = funct3_to_alu(funct3, 1'b1, instr[30]);
            end
            OPC_OP_IMM: begin
                alu_ctrl = funct3_to_alu(funct3, 1'b0, instr[30]);
                if (funct3[1:0] == 2'b01) alu_b = shamt;
            end
            OPC_BRANCH: begin
                alu_b     = rs2_data;
                is_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   alu_ctrl = ALU_SUB;
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: supported = 1'b0;
                endcase
            end
            OPC_LUI: begin
                alu_a = '0;
                alu_b = imm_u;
            end
            OPC_AUIPC: begin
                alu_a = pc;
                alu_b = imm_u;
            end
            OPC_LOAD:  alu_b = imm_i;
            OPC_STORE: alu_b = imm_s;
            OPC_JAL, OPC_JALR: begin
                alu_a = pc;
                alu_b = WIDTH'(4);
            end
            default: supported = 1'b0;
        endcase

        if (!supported) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            alu_a     = '0;
            alu_b     = '0;
            alu_ctrl  = ALU_NONE;
`else
            alu_a     = rs1_data;
            alu_b     = imm_i;
            alu_ctrl  = ALU_ADD;
`endif
            is_branch = 1'b0;
        end
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign illegal = !supported;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage toward the EX ALU, with a 2-entry skid buffer and flush.
// Optional ALU_ISSUE_ILLEGAL_EN flags unsupported encodings (see alu_decode).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   rs1_data,
    input  logic [WIDTH-1:0]   rs2_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               funct3_0,
    output logic               is_branch,
    output logic               illegal
);

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
        logic              f3_0;
        logic              branch;
        logic              illegal;
    } bundle_t;

    bundle_t    dec, main_q, skid_q;
    occ_state_t state_q, state_d;
    logic       accept, drain, load_main, load_skid, skid_to_main;

    alu_decode #(.WIDTH(WIDTH)) u_decode (
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .alu_a     (dec.a),
        .alu_b     (dec.b),
        .alu_ctrl  (dec.ctrl),
        .funct3_0  (dec.f3_0),
        .is_branch (dec.branch),
        .illegal   (dec.illegal)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (drain) begin
                    state_d      = ST_ONE;
                    skid_to_main = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != ST_FULL);
            if (load_main)         main_q <= dec;
            else if (skid_to_main) main_q <= skid_q;
            if (load_skid)         skid_q <= dec;
        end
    end

    assign alu_a     = main_q.a;
    assign alu_b     = main_q.b;
    assign alu_ctrl  = main_q.ctrl;
    assign funct3_0  = main_q.f3_0;
    assign is_branch = main_q.branch;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode table, stall/flush/reset sequences,
// and a random stream checked against a FIFO-of-bundles reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        f3;
        logic        br;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic        funct3_0, is_branch, illegal;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .funct3_0(funct3_0), .is_branch(is_branch), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference decode written straight from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        r;
        logic [2:0]  f3;
        logic [31:0] ii, ss, uu;
        logic [3:0]  opmap [8];
        bit          ok;
        opmap = '{4'd0, 4'd7, 4'd4, 4'd5, 4'd6, 4'd8, 4'd3, 4'd2};
        f3 = ins[14:12];
        ii = {{20{ins[31]}}, ins[31:20]};
        ss = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        uu = {ins[31:12], 12'h000};
        ok = 1;
        r  = '{a: r1, b: ii, ctrl: 4'd0, f3: ins[12], br: 1'b0, ill: 1'b0};
        case (ins[6:0])
            7'h33: begin
                r.b = r2;
                r.ctrl = opmap[f3];
                if (ins[30] && f3 == 3'd0) r.ctrl = 4'd1;
                if (ins[30] && f3 == 3'd5) r.ctrl = 4'd9;
            end
            7'h13: begin
                r.ctrl = opmap[f3];
                if (ins[30] && f3 == 3'd5) r.ctrl = 4'd9;
                if (f3 == 3'd1 || f3 == 3'd5) r.b = {27'd0, ins[24:20]};
            end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) ok = 0;
                else begin
                    r.b  = r2;
                    r.br = 1'b1;
                    r.ctrl = (f3 < 3'd2) ? 4'd1 : (f3 < 3'd6) ? 4'd4 : 4'd5;
                end
            end
            7'h37: begin r.a = 32'd0; r.b = uu; end
            7'h17: begin r.a = p;     r.b = uu; end
            7'h03: r.b = ii;
            7'h23: r.b = ss;
            7'h6F, 7'h67: begin r.a = p; r.b = 32'd4; end
            default: ok = 0;
        endcase
        if (!ok) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            r.a = 32'd0; r.b = 32'd0; r.ctrl = 4'hF; r.ill = 1'b1;
`else
            r.a = r1; r.b = ii; r.ctrl = 4'd0;
`endif
            r.br = 1'b0;
        end
        return r;
    endfunction

    // Drive one cycle of inputs and advance the model to the following edge.
    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl, output bit acc);
        bit drn;
        in_valid = iv; instr = ins; pc = p; rs1_data = r1; rs2_data = r2;
        out_ready = ordy; flush = fl;
        acc = 0;
        if (fl) q.delete();
        else begin
            acc = iv && (q.size() < 2);
            drn = (q.size() > 0) && ordy;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(ins, p, r1, r2));
        end
    endtask

    task automatic check_model(input string name);
        exp_t e;
        bit   bad;
        vectors++;
        bad = (out_valid !== (q.size() > 0)) || (in_ready !== (q.size() < 2));
        e = (q.size() > 0) ? q[0] : '0;
        if (q.size() > 0 && {alu_a, alu_b, alu_ctrl, funct3_0, is_branch, illegal} !== e)
            bad = 1;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got v=%b r=%b a=%h b=%h c=%h f3=%b br=%b il=%b, want v=%b r=%b a=%h b=%h c=%h f3=%b br=%b il=%b",
                     name, out_valid, in_ready, alu_a, alu_b, alu_ctrl, funct3_0, is_branch, illegal,
                     q.size() > 0, q.size() < 2, e.a, e.b, e.ctrl, e.f3, e.br, e.ill);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                input logic f3, input logic br, input logic il);
        return '{instr: ins, pc: p, rs1: r1, rs2: r2,
                 e: '{a: a, b: b, ctrl: c, f3: f3, br: br, ill: il}};
    endfunction

    initial begin
        vec_t       tbl[$];
        exp_t       got;
        bit         acc;
        logic [31:0] x0, x1, x2, y, rnd, ci, cp, c1, c2;
        logic [6:0] opcs [12];
        logic       civ;

        opcs = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h7F, 7'h0F, 7'h73};

        tbl.push_back(mk(32'h002081B3, 0, 32'h10, 3, 32'h10, 3, 4'h0, 0, 0, 0));
        tbl.push_back(mk(32'h402081B3, 0, 32'h10, 3, 32'h10, 3, 4'h1, 0, 0, 0));
        tbl.push_back(mk({7'b0100000, 5'd4, 5'd1, 3'b101, 5'd3, 7'b0010011}, 0, 32'h8000_0000, 32'hDEAD,
                         32'h8000_0000, 4, 4'h9, 1, 0, 0));
        tbl.push_back(mk({7'b0, 5'd2, 5'd1, 3'b101, 5'd0, 7'b1100011}, 0, 5, 7, 5, 7, 4'h4, 1, 1, 0));
        tbl.push_back(mk(32'h123450B7, 0, 32'hFFFF, 1, 0, 32'h1234_5000, 4'h0, 1, 0, 0));
        tbl.push_back(mk({20'h00001, 5'd1, 7'b0010111}, 32'h1000, 9, 9, 32'h1000, 32'h1000, 4'h0, 1, 0, 0));
        tbl.push_back(mk({12'hFFC, 5'd1, 3'b010, 5'd2, 7'b0000011}, 0, 100, 1, 100, 32'hFFFF_FFFC, 4'h0, 0, 0, 0));
        tbl.push_back(mk({7'h7F, 5'd2, 5'd1, 3'b010, 5'b11000, 7'b0100011}, 0, 32'h200, 1,
                         32'h200, 32'hFFFF_FFF8, 4'h0, 0, 0, 0));
        tbl.push_back(mk({20'h00010, 5'd1, 7'b1101111}, 32'h40, 7, 7, 32'h40, 4, 4'h0, 0, 0, 0));
        tbl.push_back(mk({7'b0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 0, 1, 2, 1, 2, 4'h5, 0, 1, 0));
        tbl.push_back(mk({12'hFFF, 5'd1, 3'b011, 5'd2, 7'b0010011}, 0, 3, 0, 3, 32'hFFFF_FFFF, 4'h5, 1, 0, 0));
        tbl.push_back(mk({7'b0, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011}, 0, 32'hF0, 32'h0F, 32'hF0, 32'h0F, 4'h6, 0, 0, 0));
`ifdef ALU_ISSUE_ILLEGAL_EN
        tbl.push_back(mk({12'h005, 5'd1, 3'b000, 5'd1, 7'h7F}, 0, 10, 9, 0, 0, 4'hF, 0, 0, 1));
        tbl.push_back(mk({7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011}, 0, 6, 8, 0, 0, 4'hF, 0, 0, 1));
`else
        tbl.push_back(mk({12'h005, 5'd1, 3'b000, 5'd1, 7'h7F}, 0, 10, 9, 10, 5, 4'h0, 0, 0, 0));
        tbl.push_back(mk({7'b0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011}, 0, 6, 8, 6, 2, 4'h0, 0, 0, 0));
`endif

        // Reset state
        rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
        instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
        repeat (2) @(negedge clk);
        check_model("reset_state");
        check_bit("reset_zero_payload", |{alu_a, alu_b, alu_ctrl, funct3_0, is_branch, illegal}, 1'b0);
        rst_n = 1'b1;

        // Directed table, issued back to back with out_ready high
        for (int i = 0; i <= tbl.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                got = '{a: alu_a, b: alu_b, ctrl: alu_ctrl, f3: funct3_0, br: is_branch, ill: illegal};
                vectors++;
                if (out_valid !== 1'b1 || got !== tbl[i-1].e) begin
                    miscompares++;
                    $display("FAIL table[%0d]: got v=%b %h, want v=1 %h", i - 1, out_valid, got, tbl[i-1].e);
                end
            end
            if (i < tbl.size())
                drive(1, tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, 1, 0, acc);
            else
                drive(0, 0, 0, 0, 0, 1, 0, acc);
        end
        @(negedge clk); check_model("table_drained");

        // Stall: out_ready low for 3 cycles, in_valid high
        x0 = 32'h00308133; x1 = 32'h40308133; x2 = {12'h7FF, 5'd1, 3'b000, 5'd2, 7'b0010011};
        drive(1, x0, 0, 11, 22, 0, 0, acc);
        @(negedge clk); check_model("stall_c1");
        drive(1, x1, 0, 33, 44, 0, 0, acc);
        @(negedge clk); check_model("stall_c2");
        check_bit("stall_in_ready_low", in_ready, 1'b0);
        drive(1, x2, 0, 55, 66, 0, 0, acc);
        @(negedge clk); check_model("stall_c3_hold");
        check_bit("stall_main_stable", alu_a === 32'd11 && alu_b === 32'd22, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(!acc, x2, 0, 55, 66, 1, 0, acc);
            @(negedge clk); check_model("stall_release");
        end

        // Flush while FULL with a same-cycle input
        y = {12'h123, 5'd1, 3'b000, 5'd2, 7'b0010011};
        drive(1, x0, 0, 1, 2, 0, 0, acc); @(negedge clk);
        drive(1, x1, 0, 3, 4, 0, 0, acc); @(negedge clk);
        check_bit("flush_pre_full", in_ready, 1'b0);
        drive(1, y, 0, 5, 6, 1, 1, acc);
        @(negedge clk);
        check_bit("flush_out_valid", out_valid, 1'b0);
        check_bit("flush_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0, acc);
            @(negedge clk); check_model("flush_no_issue");
        end

        // Asynchronous reset while holding an entry
        drive(1, x0, 0, 7, 8, 0, 0, acc);
        @(negedge clk); check_model("pre_reset_hold");
        drive(0, 0, 0, 0, 0, 0, 0, acc);
        #2 rst_n = 1'b0; q.delete();
        #1 check_model("midreset_state");
        check_bit("midreset_zero_payload", |{alu_a, alu_b, alu_ctrl}, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Random stream against the model; a pending input is held until accepted
        civ = 0; ci = 0; cp = 0; c1 = 0; c2 = 0; acc = 0;
        for (int n = 0; n < 400; n++) begin
            if (!civ || acc) begin
                civ = ($urandom_range(0, 9) < 7);
                rnd = $urandom();
                ci  = {rnd[31:7], opcs[$urandom_range(0, 11)]};
                cp  = $urandom(); c1 = $urandom(); c2 = $urandom();
            end
            drive(civ, ci, cp, c1, c2, ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0), acc);
            if (flush) acc = 1;
            @(negedge clk);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
